// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache AXI refill path.
package icache_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W   = $clog2(LINE_WORDS * 4);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} refill_state_t;
endpackage

// File: rtl/icache_axi_refill_if.sv
// AXI4 read-address and read-data channels used by the refill master.
interface icache_axi_refill_if #(parameter int ID_W = 4);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/icache_axi_refill.sv
// I-cache line refill: one LINE_WORDS-beat AXI read burst per miss, line granted in parallel.
// ICACHE_REFILL_WRAP_EN selects a critical-word-first WRAP burst instead of aligned INCR.
module icache_axi_refill
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
  parameter int ID_W       = 4,
  parameter int ARID_VAL   = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rd_req_i,
  input  logic [31:0]                  rd_addr_i,
  output logic                         gnt_o,
  output logic [LINE_WORDS-1:0][31:0]  line_data_o,
  output logic                         err_o,
  icache_axi_refill_if.master          axi
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;

  refill_state_t               state_q, state_d;
  logic [31:0]                 araddr_q, araddr_d;
  logic [IDX_W-1:0]            beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]            slot;
  logic                        err_q, err_d;
  logic [LINE_WORDS-1:0]       we;
  logic [LINE_WORDS-1:0][31:0] line_q;
  logic [31:0]                 addr_mask;

`ifdef ICACHE_REFILL_WRAP_EN
  // Word offset travels in araddr so beats land in their natural slot.
  assign addr_mask   = ~32'h3;
  assign slot        = araddr_q[OFF_W-1:2] + beat_cnt_q;
  assign axi.arburst = AXI_BURST_WRAP;
`else
  assign addr_mask   = ~32'((1 << OFF_W) - 1);
  assign slot        = beat_cnt_q;
  assign axi.arburst = AXI_BURST_INCR;
`endif

  assign axi.arid   = ID_W'(ARID_VAL);
  assign axi.araddr = araddr_q;
  assign axi.arlen  = 8'(LINE_WORDS - 1);
  assign axi.arsize = AXI_SIZE_4B;
  assign err_o       = err_q;
  assign line_data_o = line_q;

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    we          = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    gnt_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req_i) begin
          araddr_d = rd_addr_i & addr_mask;
          state_d  = AR;
        end
      end
      AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          beat_cnt_d = '0;
          state_d    = R;
        end
      end
      R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          we[slot]   = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (axi.rresp != AXI_RESP_OKAY) err_d = 1'b1;
          // The beat count, not rlast, terminates the burst; rlast only audits it.
          if (beat_cnt_q == IDX_W'(LINE_WORDS - 1)) begin
            state_d = DONE;
            if (!axi.rlast) err_d = 1'b1;
          end else if (axi.rlast) begin
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        gnt_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_line
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    line_q[i] <= '0;
      else if (we[i]) line_q[i] <= axi.rdata;
    end
  end
endmodule

// File: tb/tb_icache_axi_refill.sv
// Self-checking bench for icache_axi_refill: scripted AXI slave, scoreboard on gnt.
// Build with +define+ICACHE_REFILL_WRAP_EN to exercise the critical-word-first variant.
module tb_icache_axi_refill;
  localparam int LW = 8;

  typedef struct {
    logic [LW*32-1:0] line;
    logic             err;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                rd_req;
  logic [31:0]         rd_addr;
  logic                gnt;
  logic [LW-1:0][31:0] line_data;
  logic                err;

  icache_axi_refill_if #(.ID_W(4)) axi ();

  icache_axi_refill #(.LINE_WORDS(LW), .ID_W(4), .ARID_VAL(0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_req_i    (rd_req),
    .rd_addr_i   (rd_addr),
    .gnt_o       (gnt),
    .line_data_o (line_data),
    .err_o       (err),
    .axi         (axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  logic err_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LW*32-1:0] act, input logic [LW*32-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every gnt must match the oldest outstanding expected line.
  always @(negedge clk) begin
    if (rst_n && gnt) begin
      if (sb_q.size() == 0) chk("sb_unexpected_gnt", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_line", line_data, e.line);
        chk("sb_err", err, e.err);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = '0;
    err_exp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_err", err, 0);
    chk("rst_line", line_data, 0);
    chk("rst_araddr", axi.araddr, 0);
    rst_n = 1'b1;
  endtask

  // Starts and finishes on a negedge; abort_at>=0 pulses reset while that beat is offered.
  task automatic run_burst(input logic [31:0] addr, input logic [31:0] base,
                           input int ar_stall, input bit rv_toggle,
                           input int bad_resp, input int early_last, input bit drop_last,
                           input int abort_at);
    exp_t        e;
    int          c0, start;
    logic [31:0] exp_araddr;
`ifdef ICACHE_REFILL_WRAP_EN
    start      = int'(addr[4:2]);
    exp_araddr = {addr[31:2], 2'b00};
`else
    start      = 0;
    exp_araddr = {addr[31:5], 5'b0};
`endif
    if (bad_resp >= 0 || early_last >= 0 || drop_last) err_exp = 1'b1;
    for (int i = 0; i < LW; i++) e.line[i*32 +: 32] = base + 32'(i);
    e.err = err_exp;
    sb_q.push_back(e);

    rd_req = 1'b1; rd_addr = addr; axi.arready = (ar_stall == 0); axi.rvalid = 1'b0;
    c0 = cyc;
    @(posedge clk); @(negedge clk);
    rd_req = 1'b0; rd_addr = 32'hDEAD_BEEF;
    chk("ar_valid", axi.arvalid, 1);
    chk("ar_addr", axi.araddr, exp_araddr);
    for (int k = 0; k < ar_stall; k++) begin
      @(posedge clk); @(negedge clk);
      chk("ar_hold_valid", axi.arvalid, 1);
      chk("ar_hold_addr", axi.araddr, exp_araddr);
    end
    axi.arready = 1'b1;
    @(posedge clk); @(negedge clk);
    axi.arready = 1'b0;
    chk("r_arvalid_low", axi.arvalid, 0);
    chk("r_rready", axi.rready, 1);
    for (int i = 0; i < LW; i++) begin
      if (rv_toggle) begin
        axi.rvalid = 1'b0;
        @(posedge clk); @(negedge clk);
      end
      if (i == abort_at) begin
        axi.rvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort_arvalid", axi.arvalid, 0);
        chk("abort_rready", axi.rready, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_err", err, 0);
        void'(sb_q.pop_back());
        err_exp = 1'b0;
        axi.rvalid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      axi.rvalid = 1'b1;
      axi.rdata  = base + 32'((start + i) % LW);
      axi.rresp  = (i == bad_resp) ? 2'b10 : 2'b00;
      axi.rlast  = (i == early_last) || (i == LW-1 && !drop_last);
      @(posedge clk); @(negedge clk);
      axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    end
    chk("done_gnt", gnt, 1);
    chk("done_latency", cyc - c0, 10 + ar_stall + (rv_toggle ? LW : 0));
    @(posedge clk); @(negedge clk);
    chk("gnt_pulse_end", gnt, 0);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("ar_arlen", axi.arlen, 7);
    chk("ar_arsize", axi.arsize, 3'b010);
    chk("ar_arid", axi.arid, 0);
`ifdef ICACHE_REFILL_WRAP_EN
    chk("ar_arburst", axi.arburst, 2'b10);
`else
    chk("ar_arburst", axi.arburst, 2'b01);
`endif
    // Min-latency refill, then back-to-back with stalls and toggling rvalid.
    run_burst(32'h1FC0_0024, 32'h0000_00A0, 0, 0, -1, -1, 0, -1);
    run_burst(32'h1FC0_1000, 32'h0000_0100, 5, 1, -1, -1, 0, -1);
    // Bad response on beat 3: sticky error survives the following clean burst.
    run_burst(32'h0000_2040, 32'h0000_0200, 0, 0, 2, -1, 0, -1);
    run_burst(32'h0000_3060, 32'h0000_0300, 2, 0, -1, -1, 0, -1);
    do_reset();
    // Early rlast on beat 5.
    run_burst(32'h0000_4080, 32'h0000_0400, 0, 0, -1, 4, 0, -1);
    do_reset();
    // Missing rlast on the final beat.
    run_burst(32'h0000_50A0, 32'h0000_0500, 1, 1, -1, -1, 1, -1);
    do_reset();
    // Reset during beat 4 aborts; then a full refill must still work.
    run_burst(32'h0000_60C0, 32'h0000_0600, 0, 0, -1, -1, 0, 3);
    chk("post_abort_line", line_data, 0);
    @(negedge clk);
    run_burst(32'h0000_70E0, 32'h0000_0700, 0, 0, -1, -1, 0, -1);
    // Mid-line critical word: WRAP build streams 5,6,7,0..4.
    run_burst(32'h1FC0_0034, 32'h0000_0800, 0, 1, -1, -1, 0, -1);
    repeat (3) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
